coax_tx_scheduler: RTL and testbench
====================================

# coax_tx_scheduler

Sequences transmission of queued 10-bit coax words from the `coax_buffer` transmit FIFO into the coax transmitter. It decides when a frame starts (host command or FIFO pressure), fetches words one at a time from the buffer, and presents each word to the transmitter under a ready/strobe handshake. It marks the last word of each frame and aborts cleanly on transmitter stall. It sits between the host register interface, the transmit `coax_buffer` instance and `coax_tx`.

## Interface
- `AUTO_START`, 1: when 1, `buf_almost_full` high in IDLE starts a frame without a host command.
- `TX_TIMEOUT`, 4096: maximum cycles SEND may wait for `tx_ready` before aborting; must be ≥ 2.
- `COUNT_WIDTH`, 16: width of `words_sent`.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; request a frame from current buffer contents.
- `abort`  in  1  one-cycle pulse; terminate the current frame.
- `buf_read_data`  in  10  FIFO output word; valid the cycle after `buf_read_strobe`.
- `buf_read_strobe`  out  1  FIFO pop; asserted for exactly one cycle per word.
- `buf_empty`  in  1  FIFO empty.
- `buf_almost_full`  in  1  FIFO almost-full flag.
- `tx_data`  out  10  word to transmitter; stable while `tx_strobe` is high.
- `tx_strobe`  out  1  word valid; transfer occurs when `tx_strobe && tx_ready`.
- `tx_last`  out  1  qualifies `tx_data` as the final word of the frame.
- `tx_ready`  in  1  transmitter can accept a word this cycle.
- `tx_active`  in  1  transmitter is driving the line.
- `busy`  out  1  high in every state except IDLE.
- `timeout_error`  out  1  sticky; set on a TX_TIMEOUT abort, cleared by the next accepted `start`.
- `words_sent`  out  COUNT_WIDTH  words transferred in the current or most recent frame; saturates at all-ones.

## Operation
- **Reset values.** All outputs are 0 and the state is IDLE. `tx_data` resets to 10'h000.
- **States.** IDLE, FETCH, LOAD, SEND, DRAIN.
- **IDLE.** Moves to FETCH when `!buf_empty && (start || (AUTO_START && buf_almost_full))`.
  - Entering FETCH clears `words_sent` and, on `start`, clears `timeout_error`.
  - `start` while `buf_empty` is ignored: no state change and the error flag is kept.
- **FETCH.** Asserts `buf_read_strobe` for one cycle, then moves to LOAD.
- **LOAD.**
  - Registers `buf_read_data` into `tx_data`.
  - Registers `tx_last <= buf_empty`; in this cycle `buf_empty` already reflects the pop.
  - Moves to SEND.
- **SEND.**
  - Holds `tx_strobe` high with `tx_data` and `tx_last` stable.
  - On `tx_ready`: increment `words_sent` (saturating), drop `tx_strobe`, then go to DRAIN if `tx_last`, else FETCH.
  - Words written into the buffer during a frame extend that frame, as long as the buffer is non-empty at LOAD.
- **DRAIN.** Waits for `tx_active` low, then returns to IDLE. This guarantees frame separation before the next start.
- **Timeout.**
  - A wait counter is cleared on entry to SEND.
  - It counts each cycle with `tx_strobe && !tx_ready`.
  - When it reaches `TX_TIMEOUT`: set `timeout_error`, drop `tx_strobe`, go to DRAIN.
  - The held word is discarded. Remaining buffer contents are left in place.
- **Abort.** `abort` in FETCH, LOAD or SEND goes to DRAIN next cycle and drops `tx_strobe`.
  - A pop already issued in FETCH is completed: the word is lost, not pushed back.
  - `abort` in IDLE or DRAIN has no effect.
- **Simultaneous events.**
  - `abort` has priority over `tx_ready` in the same cycle: the word counts as not sent.
  - `start` and `abort` together in IDLE: start wins.
- **Mid-operation reset.** `reset_n` low forces IDLE and all-zero outputs immediately (asynchronously), including dropping `buf_read_strobe` and `tx_strobe`.

## Timing
- **Start latency.** `start` (cycle 0) → `buf_read_strobe` at cycle 1 → `tx_strobe` at cycle 3.
- **Per-word cost.** FETCH + LOAD + SEND = 3 cycles minimum. Peak rate is 1 word / 3 clk, far above the coax word rate.
- **Pop spacing.** `buf_read_strobe` is never asserted in two consecutive cycles. This keeps the buffer's registered level/flag pipeline consistent.
- **Empty flag sampling.** `buf_empty` is sampled only in IDLE and LOAD.
- **Threshold flags.** The almost-full flag lags by up to 3 cycles in the buffer, which only affects the auto-start point.
- **Return to IDLE.** DRAIN → IDLE takes 1 cycle after `tx_active` is seen low.

## Structure
- Shared package `coax_pkg` holds:
  - the state enum encoding (IDLE=0, FETCH=1, LOAD=2, SEND=3, DRAIN=4, 3 bits);
  - `COAX_WORD_WIDTH = 10`.
- One natural sub-module, `coax_tx_watchdog`: the loadable timeout counter, with clear, count-enable and an expired flag. It is reused by the receive side.
- Everything else is a single FSM with registered outputs. Target size is about 200 lines.

## Test plan
- **Normal frame.** Buffer preloaded with 3'h{0x101,0x0A5,0x3FF}; pulse `start` with `tx_ready`=1 → three `tx_strobe` transfers in that order, `tx_last` only on 0x3FF, `words_sent`=3, `busy` low after `tx_active` falls.
- **Ready backpressure.** `tx_ready` held low 10 cycles per word → `tx_data` stable throughout, exactly one `buf_read_strobe` per word, no timeout.
- **Timeout.** `TX_TIMEOUT`=8, `tx_ready` stuck 0 → `timeout_error`=1 after 8 strobe cycles, DRAIN, IDLE; the next `start` clears the flag.
- **Auto-start and frame extension.** Auto-start via `buf_almost_full` with `AUTO_START`=1, plus host writes during the frame → frame extends; `tx_last` is set only when the buffer is empty at LOAD. `start` on an empty buffer → no activity.
- **Abort and reset.** `abort` coincident with `tx_ready` in SEND → word not counted, no `tx_last`. `reset_n` asserted mid-SEND → all outputs 0 the same cycle, IDLE on release.

Source files
------------

// File: rtl/coax_pkg.sv
// ---------------------------------------------------------------------------
// coax_pkg
// Shared definitions for the coax transmit/receive datapath.
//   COAX_WORD_WIDTH : width of one coax word on the buffer and transmitter.
//   tx_state_e      : transmit scheduler state encoding (3 bits).
// ---------------------------------------------------------------------------
package coax_pkg;

    localparam int COAX_WORD_WIDTH = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DRAIN = 3'd4
    } tx_state_e;

endpackage : coax_pkg

// File: rtl/coax_tx_watchdog.sv
// ---------------------------------------------------------------------------
// coax_tx_watchdog
// Stall counter used to bound how long a handshake may wait. Also used by
// the receive side.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : restart the count at zero (wins over count_en)
//   count_en     : count one stalled cycle
//   expired      : high in the cycle that is the LIMIT-th counted cycle
// ---------------------------------------------------------------------------
module coax_tx_watchdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int WIDTH = $clog2(LIMIT + 1);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // NOTE: every combinational output gets its default before any branch,
    // so no path can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != LAST)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Expiry is flagged on the stalled cycle that brings the total to LIMIT,
    // so the owner can react at the same edge.
    assign expired = count_en && (count_q == LAST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : coax_tx_watchdog

// File: rtl/coax_tx_scheduler.sv
// ---------------------------------------------------------------------------
// coax_tx_scheduler
// Moves words from the transmit coax_buffer into coax_tx, one word per
// FETCH/LOAD/SEND pass, marking the last word of each frame and aborting on
// host request or transmitter stall.
//   clk, reset_n       : clock, asynchronous active-low reset
//   start, abort       : host one-cycle pulses
//   buf_read_data      : FIFO word, valid the cycle after buf_read_strobe
//   buf_read_strobe    : FIFO pop, one cycle per word
//   buf_empty          : FIFO empty (sampled in IDLE and LOAD only)
//   buf_almost_full    : FIFO pressure, auto-starts a frame if AUTO_START
//   tx_data/strobe/last: word offered to the transmitter
//   tx_ready           : transmitter accepts a word when high with tx_strobe
//   tx_active          : transmitter still driving the line
//   busy               : scheduler is not in IDLE
//   timeout_error      : sticky stall abort flag, cleared by an accepted start
//   words_sent         : words transferred in the current/last frame
// ---------------------------------------------------------------------------
module coax_tx_scheduler
    import coax_pkg::*;
#(
    parameter bit AUTO_START  = 1'b1,
    parameter int TX_TIMEOUT  = 4096,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [COAX_WORD_WIDTH-1:0] buf_read_data,
    output logic                       buf_read_strobe,
    input  logic                       buf_empty,
    input  logic                       buf_almost_full,
    output logic [COAX_WORD_WIDTH-1:0] tx_data,
    output logic                       tx_strobe,
    output logic                       tx_last,
    input  logic                       tx_ready,
    input  logic                       tx_active,
    output logic                       busy,
    output logic                       timeout_error,
    output logic [COUNT_WIDTH-1:0]     words_sent
);

    tx_state_e                  state_q, state_d;
    logic                       buf_read_strobe_q, buf_read_strobe_d;
    logic [COAX_WORD_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                       tx_strobe_q, tx_strobe_d;
    logic                       tx_last_q, tx_last_d;
    logic                       timeout_error_q, timeout_error_d;
    logic [COUNT_WIDTH-1:0]     words_sent_q, words_sent_d;

    logic wd_clear;
    logic wd_count_en;
    logic wd_expired;

    // The wait counter restarts in LOAD, i.e. on every entry to SEND.
    assign wd_clear    = (state_q == ST_LOAD);
    assign wd_count_en = (state_q == ST_SEND) && tx_strobe_q && !tx_ready;

    coax_tx_watchdog #(
        .LIMIT (TX_TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (wd_clear),
        .count_en (wd_count_en),
        .expired  (wd_expired)
    );

    always_comb begin
        state_d           = state_q;
        buf_read_strobe_d = 1'b0;
        tx_data_d         = tx_data_q;
        tx_strobe_d       = tx_strobe_q;
        tx_last_d         = tx_last_q;
        timeout_error_d   = timeout_error_q;
        words_sent_d      = words_sent_q;

        case (state_q)
            ST_IDLE: begin
                // start wins over a simultaneous abort: abort is not looked at here.
                if (!buf_empty && (start || (AUTO_START && buf_almost_full))) begin
                    state_d           = ST_FETCH;
                    buf_read_strobe_d = 1'b1;
                    words_sent_d      = '0;
                    if (start) begin
                        timeout_error_d = 1'b0;
                    end
                end
            end

            ST_FETCH: begin
                // The pop is already on the bus this cycle; an abort loses that word.
                state_d = abort ? ST_DRAIN : ST_LOAD;
            end

            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_DRAIN;
                end else begin
                    tx_data_d   = buf_read_data;
                    // buf_empty already reflects the pop issued in FETCH.
                    tx_last_d   = buf_empty;
                    tx_strobe_d = 1'b1;
                    state_d     = ST_SEND;
                end
            end

            ST_SEND: begin
                if (abort) begin
                    tx_strobe_d = 1'b0;
                    tx_last_d   = 1'b0;
                    state_d     = ST_DRAIN;
                end else if (tx_ready) begin
                    if (words_sent_q != '1) begin
                        words_sent_d = words_sent_q + COUNT_WIDTH'(1);
                    end
                    tx_strobe_d = 1'b0;
                    tx_last_d   = 1'b0;
                    if (tx_last_q) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d           = ST_FETCH;
                        buf_read_strobe_d = 1'b1;
                    end
                end else if (wd_expired) begin
                    // The held word is dropped; the buffer keeps the rest.
                    timeout_error_d = 1'b1;
                    tx_strobe_d     = 1'b0;
                    tx_last_d       = 1'b0;
                    state_d         = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (!tx_active) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                tx_strobe_d = 1'b0;
                tx_last_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= ST_IDLE;
            buf_read_strobe_q <= 1'b0;
            tx_data_q         <= '0;
            tx_strobe_q       <= 1'b0;
            tx_last_q         <= 1'b0;
            timeout_error_q   <= 1'b0;
            words_sent_q      <= '0;
        end else begin
            state_q           <= state_d;
            buf_read_strobe_q <= buf_read_strobe_d;
            tx_data_q         <= tx_data_d;
            tx_strobe_q       <= tx_strobe_d;
            tx_last_q         <= tx_last_d;
            timeout_error_q   <= timeout_error_d;
            words_sent_q      <= words_sent_d;
        end
    end

    assign buf_read_strobe = buf_read_strobe_q;
    assign tx_data         = tx_data_q;
    assign tx_strobe       = tx_strobe_q;
    assign tx_last         = tx_last_q;
    assign timeout_error   = timeout_error_q;
    assign words_sent      = words_sent_q;
    assign busy            = (state_q != ST_IDLE);

endmodule : coax_tx_scheduler

// File: tb/tb_coax_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_coax_tx_scheduler
// Two instances: dut (AUTO_START=1, TX_TIMEOUT=32) with a FIFO model and
// scoreboard, and dut_to (AUTO_START=0, TX_TIMEOUT=8) for the stall abort.
// ---------------------------------------------------------------------------
module tb_coax_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // main instance
    logic        start, abort, buf_empty, buf_almost_full, tx_ready, tx_active;
    logic [9:0]  buf_read_data;
    logic        buf_read_strobe, tx_strobe, tx_last, busy, timeout_error;
    logic [9:0]  tx_data;
    logic [15:0] words_sent;

    // timeout instance
    logic        t_start, t_abort, t_buf_empty, t_almost_full, t_tx_ready, t_tx_active;
    logic [9:0]  t_buf_read_data;
    logic        t_buf_read_strobe, t_tx_strobe, t_tx_last, t_busy, t_timeout_error;
    logic [9:0]  t_tx_data;
    logic [15:0] t_words_sent;

    coax_tx_scheduler #(.AUTO_START(1'b1), .TX_TIMEOUT(32), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .buf_read_data(buf_read_data), .buf_read_strobe(buf_read_strobe),
        .buf_empty(buf_empty), .buf_almost_full(buf_almost_full),
        .tx_data(tx_data), .tx_strobe(tx_strobe), .tx_last(tx_last),
        .tx_ready(tx_ready), .tx_active(tx_active), .busy(busy),
        .timeout_error(timeout_error), .words_sent(words_sent)
    );

    coax_tx_scheduler #(.AUTO_START(1'b0), .TX_TIMEOUT(8), .COUNT_WIDTH(16)) dut_to (
        .clk(clk), .reset_n(reset_n), .start(t_start), .abort(t_abort),
        .buf_read_data(t_buf_read_data), .buf_read_strobe(t_buf_read_strobe),
        .buf_empty(t_buf_empty), .buf_almost_full(t_almost_full),
        .tx_data(t_tx_data), .tx_strobe(t_tx_strobe), .tx_last(t_tx_last),
        .tx_ready(t_tx_ready), .tx_active(t_tx_active), .busy(t_busy),
        .timeout_error(t_timeout_error), .words_sent(t_words_sent)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // ---------------- FIFO model (written by stimulus, popped by DUT) -------
    logic [9:0] mem [0:63];
    int wr_cnt = 0;
    int rd_cnt = 0;
    assign buf_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (buf_read_strobe) begin
            buf_read_data <= mem[rd_cnt[5:0]];
            rd_cnt        <= rd_cnt + 1;
        end
    end

    // ---------------- scoreboard ---------------------------------------------
    logic [9:0] exp_data_q [$];
    logic       exp_last_q [$];

    task automatic push_word(input logic [9:0] w, input logic has_exp, input logic last);
        mem[wr_cnt[5:0]] = w;
        wr_cnt++;
        if (has_exp) begin
            exp_data_q.push_back(w);
            exp_last_q.push_back(last);
        end
    endtask

    int   xfer_cnt = 0;
    int   rs_cnt   = 0;
    logic prev_rs = 1'b0, prev_ts = 1'b0, prev_xfer = 1'b0;
    logic [9:0] prev_data = '0;

    always @(negedge clk) begin
        logic [9:0] ed;
        logic       el;
        if (buf_read_strobe) begin
            rs_cnt++;
            check("pop_spacing", prev_rs, 1'b0);
            check("pop_when_nonempty", wr_cnt > rd_cnt, 1'b1);
        end
        if (tx_strobe && prev_ts && !prev_xfer)
            check("data_stable", tx_data, prev_data);
        if (tx_strobe && tx_ready && !abort) begin
            check("xfer_expected", exp_data_q.size() != 0, 1'b1);
            if (exp_data_q.size() != 0) begin
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                check("tx_data", tx_data, ed);
                check("tx_last", tx_last, el);
            end
            xfer_cnt++;
        end
        prev_rs   = buf_read_strobe;
        prev_ts   = tx_strobe;
        prev_xfer = tx_strobe && tx_ready;
        prev_data = tx_data;
    end

    // ---------------- helpers ------------------------------------------------
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_t_start();
        @(posedge clk); #1 t_start = 1'b1;
        @(posedge clk); #1 t_start = 1'b0;
    endtask

    task automatic wait_strobe(input string tag);
        int n = 0;
        @(negedge clk);
        while (!tx_strobe && n < 100) begin @(negedge clk); n++; end
        check({tag, "_strobe_seen"}, tx_strobe, 1'b1);
    endtask

    task automatic wait_xfers(input int target);
        int n = 0;
        while (xfer_cnt < target && n < 400) begin @(negedge clk); n++; end
        check("xfer_count", xfer_cnt, target);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- stimulus -----------------------------------------------
    initial begin
        int base;
        int n;
        reset_n = 1'b0;
        start = 0; abort = 0; buf_almost_full = 0; tx_ready = 0; tx_active = 0;
        buf_read_data = '0;
        t_start = 0; t_abort = 0; t_buf_empty = 1; t_almost_full = 0;
        t_tx_ready = 0; t_tx_active = 0; t_buf_read_data = 10'h2C5;

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_strobe", tx_strobe, 1'b0);
        check("rst_read_strobe", buf_read_strobe, 1'b0);
        check("rst_tx_data", tx_data, 10'h000);
        check("rst_tx_last", tx_last, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout_error", timeout_error, 1'b0);
        check("rst_words_sent", words_sent, 16'h0);
        @(posedge clk); #1 reset_n = 1'b1;

        // start / almost_full on an empty buffer: nothing happens
        buf_almost_full = 1'b1;
        pulse_start();
        repeat (4) @(negedge clk);
        check("empty_start_busy", busy, 1'b0);
        check("empty_start_pops", rs_cnt, 0);
        @(posedge clk); #1 buf_almost_full = 1'b0;

        // normal frame with start latency
        push_word(10'h101, 1'b1, 1'b0);
        push_word(10'h0A5, 1'b1, 1'b0);
        push_word(10'h3FF, 1'b1, 1'b1);
        tx_ready = 1'b1; tx_active = 1'b1;
        base = xfer_cnt;
        pulse_start();
        @(negedge clk); check("lat_read_strobe_c1", buf_read_strobe, 1'b1);
        @(negedge clk); check("lat_tx_strobe_c2", tx_strobe, 1'b0);
        @(negedge clk); check("lat_tx_strobe_c3", tx_strobe, 1'b1);
        wait_xfers(base + 3);
        @(negedge clk);
        check("normal_words_sent", words_sent, 16'd3);
        check("normal_drain_busy", busy, 1'b1);
        tx_active = 1'b0;
        wait_idle("normal");

        // ready backpressure, 10 stalled cycles per word
        push_word(10'h155, 1'b1, 1'b0);
        push_word(10'h2AA, 1'b1, 1'b1);
        tx_ready = 1'b0; tx_active = 1'b1;
        base = rs_cnt;
        pulse_start();
        for (int w = 0; w < 2; w++) begin
            wait_strobe("bp");
            repeat (10) @(posedge clk);
            #1 tx_ready = 1'b1;
            @(posedge clk); #1 tx_ready = 1'b0;
        end
        @(negedge clk);
        check("bp_pops", rs_cnt - base, 2);
        check("bp_no_timeout", timeout_error, 1'b0);
        check("bp_words_sent", words_sent, 16'd2);
        tx_active = 1'b0;
        wait_idle("bp");

        // auto-start on almost_full, frame extended by a write mid-frame
        @(posedge clk); #1;
        push_word(10'h011, 1'b1, 1'b0);
        push_word(10'h022, 1'b1, 1'b0);
        tx_ready = 1'b0; tx_active = 1'b1; buf_almost_full = 1'b1;
        base = xfer_cnt;
        wait_strobe("auto");
        @(posedge clk); #1;
        push_word(10'h033, 1'b1, 1'b1);
        buf_almost_full = 1'b0;
        tx_ready = 1'b1;
        wait_xfers(base + 3);
        @(negedge clk);
        check("auto_words_sent", words_sent, 16'd3);
        tx_active = 1'b0;
        wait_idle("auto");

        // abort coincident with tx_ready
        @(posedge clk); #1;
        push_word(10'h0F0, 1'b0, 1'b0);
        tx_ready = 1'b0; tx_active = 1'b1;
        pulse_start();
        wait_strobe("abort");
        check("single_word_last", tx_last, 1'b1);
        @(posedge clk); #1 abort = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1 abort = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        check("abort_tx_strobe", tx_strobe, 1'b0);
        check("abort_tx_last", tx_last, 1'b0);
        check("abort_words_sent", words_sent, 16'd0);
        check("abort_busy", busy, 1'b1);
        tx_active = 1'b0;
        wait_idle("abort");

        // asynchronous reset in SEND
        @(posedge clk); #1;
        push_word(10'h1C3, 1'b0, 1'b0);
        tx_active = 1'b1;
        pulse_start();
        wait_strobe("rst");
        check("rst_held_word", tx_data, 10'h1C3);
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        check("async_rst_tx_strobe", tx_strobe, 1'b0);
        check("async_rst_tx_data", tx_data, 10'h000);
        check("async_rst_tx_last", tx_last, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_read_strobe", buf_read_strobe, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1; tx_active = 1'b0;
        @(negedge clk);
        check("rst_release_idle", busy, 1'b0);

        // stall timeout on the TX_TIMEOUT=8 instance
        t_buf_empty = 1'b0; t_tx_ready = 1'b0; t_tx_active = 1'b1;
        pulse_t_start();
        n = 0;
        @(negedge clk);
        while (!t_tx_strobe && n < 50) begin @(negedge clk); n++; end
        check("to_strobe_seen", t_tx_strobe, 1'b1);
        check("to_tx_data", t_tx_data, 10'h2C5);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!t_tx_strobe) break;
            n++;
        end
        check("to_strobe_cycles", n, 8);
        check("to_error_set", t_timeout_error, 1'b1);
        check("to_drain_busy", t_busy, 1'b1);
        check("to_words_sent", t_words_sent, 16'd0);
        t_tx_active = 1'b0;
        n = 0;
        @(negedge clk);
        while (t_busy && n < 50) begin @(negedge clk); n++; end
        check("to_idle", t_busy, 1'b0);
        check("to_error_sticky", t_timeout_error, 1'b1);

        t_buf_empty = 1'b1;
        pulse_t_start();
        @(negedge clk);
        check("to_empty_start_busy", t_busy, 1'b0);
        check("to_empty_start_keeps_err", t_timeout_error, 1'b1);

        t_buf_empty = 1'b0; t_tx_ready = 1'b1;
        pulse_t_start();
        t_buf_empty = 1'b1;
        @(negedge clk);
        check("to_start_clears_err", t_timeout_error, 1'b0);
        n = 0;
        while (t_busy && n < 50) begin @(negedge clk); n++; end
        check("to_final_idle", t_busy, 1'b0);
        check("to_final_words_sent", t_words_sent, 16'd1);

        check("scoreboard_drained", exp_data_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_coax_tx_scheduler
